// File: rtl/ex_div_unit_pkg.sv
// Shared constants, state encoding and datapath types for the EX-stage divide unit.
package ex_div_unit_pkg;

  localparam int unsigned XLEN_W = 32;
  localparam int unsigned REM_W  = XLEN_W + 1;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned OP_W   = 2;

  localparam logic [OP_W-1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [OP_W-1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [OP_W-1:0] DIV_OP_REM  = 2'b10;
  localparam logic [OP_W-1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  // Partial remainder and quotient shifted together as one register pair
  typedef struct packed {
    logic [REM_W-1:0]  rem;
    logic [XLEN_W-1:0] quo;
  } div_acc_t;

  function automatic logic is_signed_op(input logic [OP_W-1:0] op);
    return ~op[0];
  endfunction

  function automatic logic is_rem_op(input logic [OP_W-1:0] op);
    return op[1];
  endfunction

  function automatic logic [XLEN_W-1:0] neg_if(input logic neg, input logic [XLEN_W-1:0] v);
    return neg ? XLEN_W'(-v) : v;
  endfunction

endpackage

// File: rtl/ex_div_unit_if.sv
// Request/response bundle between the EX stage and the divide unit.
interface ex_div_unit_if;
  import ex_div_unit_pkg::*;

  logic              start;
  logic [OP_W-1:0]   div_op;
  logic [XLEN_W-1:0] rs1_data;
  logic [XLEN_W-1:0] rs2_data;
  logic              flush;
  logic              busy;
  logic              done;
  logic [XLEN_W-1:0] div_result;

  modport master (
    output start, div_op, rs1_data, rs2_data, flush,
    input  busy, done, div_result
  );

  modport slave (
    input  start, div_op, rs1_data, rs2_data, flush,
    output busy, done, div_result
  );

endinterface

// File: rtl/ex_div_unit_div_step.sv
// One radix-2 restoring iteration: shift {rem, quo}, trial-subtract, keep or restore.
module div_step
  import ex_div_unit_pkg::*;
(
  input  div_acc_t          acc,
  input  logic [XLEN_W-1:0] divisor,
  output div_acc_t          acc_next
);

  logic [REM_W-1:0]  rem_sh;
  logic [XLEN_W-1:0] quo_sh;
  logic [REM_W:0]    diff;

  always_comb begin
    // rem never exceeds the divisor, so its top bit is always shifted out as zero
    rem_sh        = REM_W'({acc.rem, acc.quo[XLEN_W-1]});
    quo_sh        = {acc.quo[XLEN_W-2:0], 1'b0};
    diff          = {1'b0, rem_sh} - {2'b00, divisor};
    acc_next.rem  = rem_sh;
    acc_next.quo  = quo_sh;
    if (!diff[REM_W]) begin
      acc_next.rem = diff[REM_W-1:0];
      acc_next.quo = {quo_sh[XLEN_W-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/ex_div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit; stalls the pipeline while iterating.
module ex_div_unit
  import ex_div_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic          clk,
  input  logic          reset,
  ex_div_unit_if.slave  bus
);

  div_state_e      state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic [XLEN-1:0] divisor_q, divisor_d;
  div_acc_t        acc_q, acc_d, acc_step;
  logic [CNT_W-1:0] count_q, count_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            done_q, done_d;

  logic            signed_op;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, overflow;
  logic [XLEN-1:0] fin_quo, fin_rem;

  div_step u_div_step (
    .acc      (acc_q),
    .divisor  (divisor_q),
    .acc_next (acc_step)
  );

  // Operand classification for the accept cycle
  always_comb begin
    signed_op = is_signed_op(bus.div_op);
    a_neg     = signed_op & bus.rs1_data[XLEN-1];
    b_neg     = signed_op & bus.rs2_data[XLEN-1];
    a_mag     = a_neg ? XLEN'(-bus.rs1_data) : bus.rs1_data;
    b_mag     = b_neg ? XLEN'(-bus.rs2_data) : bus.rs2_data;
    div_zero  = (bus.rs2_data == '0);
    overflow  = signed_op && (bus.rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                          && (bus.rs2_data == '1);
    fin_quo   = neg_if(neg_quo_q, acc_step.quo);
    fin_rem   = neg_if(neg_rem_q, acc_step.rem[XLEN-1:0]);
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    divisor_d = divisor_q;
    acc_d     = acc_q;
    count_d   = count_q;
    result_d  = result_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.flush) begin
          op_d      = bus.div_op;
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          divisor_d = b_mag;
          acc_d.quo = a_mag;
          acc_d.rem = '0;
          if (div_zero) begin
            result_d = is_rem_op(bus.div_op) ? bus.rs1_data : '1;
            state_d  = ST_DONE;
          end else if (overflow) begin
            result_d = is_rem_op(bus.div_op) ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            state_d  = ST_DONE;
          end else begin
            count_d  = CNT_W'(XLEN - 1);
            state_d  = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        acc_d = acc_step;
        if (count_q == '0) begin
          result_d = is_rem_op(op_q) ? fin_rem : fin_quo;
          state_d  = ST_DONE;
        end else begin
          count_d  = count_q - CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A flushed instruction never completes and leaves the last result intact
    if (bus.flush) begin
      state_d  = ST_IDLE;
      result_d = result_q;
    end

    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      divisor_q <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      divisor_q <= divisor_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      result_q  <= result_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy       = ((state_q == ST_IDLE) && bus.start && !bus.flush) || (state_q == ST_CALC);
  assign bus.done       = done_q;
  assign bus.div_result = result_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed and randomized checks of ex_div_unit against an arithmetic reference model.
module tb_ex_div_unit;
  import ex_div_unit_pkg::*;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  logic [31:0] last_exp;

  ex_div_unit_if bus ();

  ex_div_unit #(.XLEN(32)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // RISC-V division semantics computed with 64-bit integer arithmetic
  function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (op[0]) begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end
    q = sa / sb;
    r = sa % sb;
    return op[1] ? r[31:0] : q[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge with the unit in IDLE
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit hold);
    logic [31:0] exp;
    bit          spc;
    int          cyc;
    int          bcnt;
    exp = ref_model(op, a, b);
    spc = is_special(op, a, b);
    bus.start    = 1'b1;
    bus.div_op   = op;
    bus.rs1_data = a;
    bus.rs2_data = b;
    #1;
    check({tag, ".busy_accept"}, 32'(bus.busy), 32'd1);
    bcnt = 1;
    @(posedge clk); #1;
    if (!hold) bus.start = 1'b0;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 40) begin
      if (bus.busy === 1'b1) bcnt++;
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, ".done_seen"}, 32'(bus.done), 32'd1);
    check({tag, ".latency"}, 32'(cyc), spc ? 32'd0 : 32'd32);
    check({tag, ".busy_cycles"}, 32'(bcnt), spc ? 32'd1 : 32'd33);
    check({tag, ".busy_in_done"}, 32'(bus.busy), 32'd0);
    check({tag, ".result"}, bus.div_result, exp);
    @(posedge clk); #1;
    check({tag, ".done_pulse_end"}, 32'(bus.done), 32'd0);
    check({tag, ".result_held"}, bus.div_result, exp);
    last_exp = exp;
  endtask

  initial begin
    int pulses;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    n_tests      = 0;
    n_fail       = 0;
    last_exp     = 32'd0;
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.flush    = 1'b0;
    bus.div_op   = DIV_OP_DIV;
    bus.rs1_data = 32'd0;
    bus.rs2_data = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.busy", 32'(bus.busy), 32'd0);
    check("reset.done", 32'(bus.done), 32'd0);
    check("reset.result", bus.div_result, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    run_op("div_100_7",  DIV_OP_DIV,  32'd100, 32'd7, 1'b0);
    run_op("rem_100_7",  DIV_OP_REM,  32'd100, 32'd7, 1'b0);
    run_op("div_m7_2",   DIV_OP_DIV,  32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("rem_m7_2",   DIV_OP_REM,  32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("divu_big_2", DIV_OP_DIVU, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("divu_by0",   DIV_OP_DIVU, 32'd5, 32'd0, 1'b0);
    run_op("rem_by0",    DIV_OP_REM,  32'd5, 32'd0, 1'b0);
    run_op("div_ovf",    DIV_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("rem_ovf",    DIV_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("remu_ovf",   DIV_OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    // Flush partway through CALC: no done pulse, previous result survives
    bus.start = 1'b1; bus.div_op = DIV_OP_DIV; bus.rs1_data = 32'd1000; bus.rs2_data = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush.busy_drop", 32'(bus.busy), 32'd0);
    check("flush.result_kept", bus.div_result, last_exp);
    pulses = 0;
    repeat (40) begin
      if (bus.done === 1'b1) pulses++;
      @(posedge clk); #1;
    end
    check("flush.no_done", 32'(pulses), 32'd0);

    // Flush outranks a start seen in IDLE
    bus.start = 1'b1; bus.flush = 1'b1;
    #1;
    check("flush_start.busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    #1;
    check("flush_start.idle", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    run_op("div_9_3", DIV_OP_DIV, 32'd9, 32'd3, 1'b0);

    // Reset in the middle of CALC
    bus.start = 1'b1; bus.div_op = DIV_OP_DIVU; bus.rs1_data = 32'hDEAD_BEEF; bus.rs2_data = 32'd13;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("midreset.result", bus.div_result, 32'd0);
    check("midreset.busy", 32'(bus.busy), 32'd0);
    check("midreset.done", 32'(bus.done), 32'd0);
    @(posedge clk); #1;
    check("midreset.stays_idle", 32'(bus.busy), 32'd0);

    // start held through DONE, then a fresh op accepted in the following IDLE cycle
    run_op("hold_div", DIV_OP_DIV, 32'd100, 32'd7, 1'b1);
    run_op("hold_next", DIV_OP_REMU, 32'd1234, 32'd10, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 9))
        0:       rb = 32'd0;
        1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2:       rb = 32'($urandom_range(1, 15));
        3:       rb = 32'(-$urandom_range(1, 15));
        4:       begin rb = $urandom; ra = ra >> $urandom_range(0, 31); end
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      run_op($sformatf("rand%0d", i), rop, ra, rb, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
